// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display path:
// converter FSM states, digit width and the BCD saturation limit.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned DIGITS_DEF = 4;
  localparam int unsigned DIGIT_W    = 4;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic longint unsigned bcd_max(input int unsigned digits);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = nibble;
    if (nibble >= DIGIT_W'(5)) begin
      adjusted = nibble + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary to packed-BCD converter (double-dabble, one bit per clock)
// with saturation at the display range and a held result for the 7-seg driver.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic [4*DIGITS-1:0]   display_num,
  output logic                  ovf,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int unsigned     BCD_W  = DIGIT_W * DIGITS;
  localparam int unsigned     SR_W   = BCD_W + BIN_W;
  localparam int unsigned     CNT_W  = $clog2(BIN_W + 1);
  localparam longint unsigned MAX    = bcd_max(DIGITS);
  // Saturation only exists when the input range can exceed the display range.
  localparam bit              SAT_EN = ((64'd1 << BIN_W) - 64'd1) > MAX;
  localparam logic [BIN_W-1:0] MAX_BIN = SAT_EN ? BIN_W'(MAX) : '1;

  state_t           state;
  logic [SR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;
  logic [BCD_W-1:0] bcd_adj;
  logic             over;

  assign over     = SAT_EN && (in_bin > MAX_BIN);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .nibble   (sr[BIN_W + DIGIT_W*d +: DIGIT_W]),
      .adjusted (bcd_adj[DIGIT_W*d +: DIGIT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      ovf_pend    <= 1'b0;
      display_num <= '0;
      ovf         <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr       <= {{BCD_W{1'b0}}, (over ? MAX_BIN : in_bin)};
            ovf_pend <= over;
            cnt      <= CNT_W'(BIN_W);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjusted BCD field and binary field shift together; the BCD MSB
          // is always 0 after adjustment, so dropping it loses nothing.
          sr  <= {bcd_adj[BCD_W-2:0], sr[BIN_W-1:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          display_num <= sr[SR_W-1 -: BCD_W];
          ovf         <= ovf_pend;
          out_valid   <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: vector table plus hand-written
// sequences for held input, mid-conversion reset and back-to-back streaming.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_bin;
  logic [15:0] display_num;
  logic        ovf;
  logic        out_valid;
  logic        busy;

  int unsigned tests;
  int unsigned fails;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bin      (in_bin),
    .display_num (display_num),
    .ovf         (ovf),
    .out_valid   (out_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] num;
    logic        ov;
  } vec_t;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one value, then count edges until out_valid; checks busy/in_ready on the way.
  task automatic convert(input logic [13:0] bin, input logic [15:0] exp_num,
                         input logic exp_ov, input string name);
    int unsigned k;
    logic        busy_ok;
    in_bin   = bin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_ok  = 1'b1;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        k = i;
        break;
      end
      if (!busy || in_ready) busy_ok = 1'b0;
    end
    check({name, " latency"}, k, 15);
    check({name, " busy"}, busy_ok, 1);
    check({name, " display_num"}, display_num, exp_num);
    check({name, " ovf"}, ovf, exp_ov);
    check({name, " in_ready_at_done"}, in_ready, 1);
    @(posedge clk); #1;
    check({name, " out_valid_pulse"}, out_valid, 0);
    check({name, " held"}, display_num, exp_num);
  endtask

  initial begin
    vec_t        vecs[8];
    int unsigned k;
    int unsigned last;
    int unsigned idx;
    logic        seen;
    logic [15:0] exp_stream[4];
    logic [13:0] bin_stream[4];

    tests = 0;
    fails = 0;
    vecs[0] = '{14'd0,     16'h0000, 1'b0};
    vecs[1] = '{14'd1234,  16'h1234, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd12000, 16'h9999, 1'b1};
    vecs[4] = '{14'd7,     16'h0007, 1'b0};
    vecs[5] = '{14'd16383, 16'h9999, 1'b1};
    vecs[6] = '{14'd10000, 16'h9999, 1'b1};
    vecs[7] = '{14'd8086,  16'h8086, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset ovf", ovf, 0);
    check("reset display_num", display_num, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].bin, vecs[i].num, vecs[i].ov, $sformatf("vec%0d", i));
    end

    // Held in_valid: 42 accepted, later change to 4095 must wait for idle.
    in_bin   = 14'd42;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_bin = 14'd4095;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin k = i; break; end
    end
    check("hold first latency", k, 15);
    check("hold first value", display_num, 16'h0042);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold second accepted", busy, 1);
    k = 0;
    for (int i = 17; i <= 60; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin k = i; break; end
    end
    check("hold second edge", k, 31);
    check("hold second value", display_num, 16'h4095);

    // Reset during conversion of 5678.
    in_bin   = 14'd5678;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort in_ready", in_ready, 1);
    check("abort busy", busy, 0);
    check("abort display_num", display_num, 0);
    check("abort ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort no out_valid", seen, 0);
    check("abort display_num kept", display_num, 0);
    convert(14'd5678, 16'h5678, 1'b0, "after_abort");

    // Back-to-back stream with in_valid held high.
    bin_stream[0] = 14'd1;    exp_stream[0] = 16'h0001;
    bin_stream[1] = 14'd10;   exp_stream[1] = 16'h0010;
    bin_stream[2] = 14'd100;  exp_stream[2] = 16'h0100;
    bin_stream[3] = 14'd1000; exp_stream[3] = 16'h1000;
    in_bin   = bin_stream[0];
    in_valid = 1'b1;
    idx  = 0;
    last = 0;
    for (int i = 0; i <= 100 && idx < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        check($sformatf("stream%0d spacing", idx), i - last, (idx == 0) ? 15 : 16);
        check($sformatf("stream%0d value", idx), display_num, exp_stream[idx]);
        last = i;
        idx++;
        if (idx < 4) in_bin = bin_stream[idx];
        else in_valid = 1'b0;
      end
    end
    check("stream count", idx, 4);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
